// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_pkg: shared constants, types and helpers for the digit scanner |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package seg7_pkg;

  localparam int DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [$clog2(DIGITS)-1:0] digit_idx_t;

  // Active-low one-hot anode select for a digit position.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // Digit 0 is never blanked so that a zero value still shows "0".
  function automatic logic digit_blanked(input logic [15:0] disp,
                                         input digit_idx_t  idx,
                                         input logic        blank_en);
    logic upper_zero;
    case (idx)
      2'd1:    upper_zero = (disp[15:4]  == 12'h000);
      2'd2:    upper_zero = (disp[15:8]  == 8'h00);
      2'd3:    upper_zero = (disp[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    return blank_en && upper_zero;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_scan_if: value/load/blank inputs and scan outputs of seg7_scan |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface seg7_scan_if;
  logic [15:0] value;
  logic        load;
  logic        blank_en;
  logic [3:0]  a;
  logic [3:0]  an;
  logic        committed;
  logic        frame;

  modport master (
    output value, load, blank_en,
    input  a, an, committed, frame
  );

  modport slave (
    input  value, load, blank_en,
    output a, an, committed, frame
  );
endinterface
`default_nettype wire

// File: rtl/seg7_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_tick_gen: free-running prescaler, tick on the last count      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg7_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_scan: 4-digit multiplexed scan driver with tear-free updates  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_scan_if.slave   bus
);

  localparam digit_idx_t LAST_IDX = digit_idx_t'(DIGITS - 1);

  logic        tick;
  logic        wrap;
  logic        commit;
  logic        blank;

  digit_idx_t  idx_q,    idx_d;
  logic [15:0] disp_q,   disp_d;
  logic [15:0] pend_q,   pend_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  a_q,      a_d;
  logic [3:0]  an_q,     an_d;
  logic        wrap_dly_q;
  logic        commit_dly_q;
  logic        committed_q, committed_d;
  logic        frame_q,     frame_d;

  seg7_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    idx_d    = tick ? digit_idx_t'(idx_q + digit_idx_t'(1)) : idx_q;
    wrap     = tick && (idx_q == LAST_IDX);
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    commit   = 1'b0;

    // A load on the wrap cycle bypasses pend so it is neither lost nor delayed a frame.
    if (wrap && bus.load) begin
      disp_d   = bus.value;
      pend_v_d = 1'b0;
      commit   = 1'b1;
    end else if (wrap && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
      commit   = 1'b1;
    end else if (bus.load) begin
      pend_d   = bus.value;
      pend_v_d = 1'b1;
    end
  end

  always_comb begin
    blank = digit_blanked(disp_q, idx_q, bus.blank_en);
    an_d  = blank ? AN_OFF : an_select(idx_q);
    a_d   = blank ? 4'h0 : disp_q[{idx_q, 2'b00} +: 4];
    // Pulses are delayed one extra stage so they coincide with digit 0 of the new frame on a/an.
    frame_d     = wrap_dly_q;
    committed_d = commit_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_v_q     <= 1'b0;
      a_q          <= 4'h0;
      an_q         <= AN_OFF;
      wrap_dly_q   <= 1'b0;
      commit_dly_q <= 1'b0;
      committed_q  <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      a_q          <= a_d;
      an_q         <= an_d;
      wrap_dly_q   <= wrap;
      commit_dly_q <= commit;
      committed_q  <= committed_d;
      frame_q      <= frame_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.an        = an_q;
  assign bus.committed = committed_q;
  assign bus.frame     = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seg7_scan: directed scoreboard bench for seg7_scan (SCAN_DIV=4) |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_seg7_scan;

  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  logic [15:0] exp_q[$];

  seg7_scan_if bus ();

  seg7_scan #(
    .SCAN_DIV (DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic digit_off(input logic [15:0] v, input int d, input logic blank);
    return blank && (d > 0) && ((v >> (4 * d)) == 16'h0000);
  endfunction

  function automatic logic [3:0] exp_an(input logic [15:0] v, input int d, input logic blank);
    logic [3:0] one;
    one = 4'b0001;
    return digit_off(v, d, blank) ? 4'b1111 : ~(one << d);
  endfunction

  function automatic logic [3:0] exp_a(input logic [15:0] v, input int d, input logic blank);
    return digit_off(v, d, blank) ? 4'h0 : v[4*d +: 4];
  endfunction

  // Last load before a commit wins, so a still-pending entry is overwritten.
  task automatic do_load(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = v;
    else                  exp_q.push_back(v);
    step();
    bus.load  = 1'b0;
  endtask

  task automatic wait_commit(input string tag);
    for (int i = 0; i < 80 && bus.committed !== 1'b1; i++) step();
    chk(tag, {15'h0, bus.committed}, 16'h0001);
  endtask

  task automatic pop_exp(output logic [15:0] v);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard_empty: observed commit expected none");
      v = 16'h0000;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] v,
                             input logic blank, input logic commit_exp);
    for (int j = 0; j < 4 * DIV; j++) begin
      int d;
      d = j / DIV;
      chk({tag, "_an"}, {12'h0, bus.an}, {12'h0, exp_an(v, d, blank)});
      chk({tag, "_a"},  {12'h0, bus.a},  {12'h0, exp_a(v, d, blank)});
      chk({tag, "_committed"}, {15'h0, bus.committed}, {15'h0, (j == 0) && commit_exp});
      chk({tag, "_frame"}, {15'h0, bus.frame}, {15'h0, j == 0});
      step();
    end
  endtask

  initial begin
    logic [15:0] v;
    bus.value    = 16'h0000;
    bus.load     = 1'b0;
    bus.blank_en = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", {12'h0, bus.an}, 16'h000F);
    chk("reset_a", {12'h0, bus.a}, 16'h0000);
    chk("reset_committed", {15'h0, bus.committed}, 16'h0000);
    chk("reset_frame", {15'h0, bus.frame}, 16'h0000);

    rst_n = 1'b1;
    step();
    chk("first_an", {12'h0, bus.an}, 16'h000E);
    chk("first_a", {12'h0, bus.a}, 16'h0000);

    // Plain load in frame 0, committed at the first wrap.
    step();
    do_load(16'h1234);
    wait_commit("commit_1234");
    pop_exp(v);
    check_frame("scan_1234", v, 1'b0, 1'b1);
    chk("frame_period", {15'h0, bus.frame}, 16'h0001);
    chk("no_extra_commit", {15'h0, bus.committed}, 16'h0000);

    // Leading-zero blanking.
    bus.blank_en = 1'b1;
    do_load(16'h0007);
    wait_commit("commit_0007");
    pop_exp(v);
    check_frame("blank_0007", v, 1'b1, 1'b1);
    do_load(16'h0000);
    wait_commit("commit_0000");
    pop_exp(v);
    check_frame("blank_0000", v, 1'b1, 1'b1);

    // Two mid-frame loads at idx=1: display holds until wrap, last one wins.
    bus.blank_en = 1'b0;
    repeat (DIV) step();
    do_load(16'hAAAA);
    do_load(16'hBBBB);
    chk("hold_an", {12'h0, bus.an}, 16'h000D);
    chk("hold_a", {12'h0, bus.a}, 16'h0000);
    chk("hold_committed", {15'h0, bus.committed}, 16'h0000);
    wait_commit("commit_bbbb");
    pop_exp(v);
    check_frame("scan_bbbb", v, 1'b0, 1'b1);

    // Load exactly on the wrap cycle goes straight to the display.
    repeat (4 * DIV - 2) step();
    do_load(16'h5A5A);
    step();
    pop_exp(v);
    check_frame("wrap_5a5a", v, 1'b0, 1'b1);
    chk("wrap_no_recommit", {15'h0, bus.committed}, 16'h0000);
    chk("wrap_next_a", {12'h0, bus.a}, 16'h000A);

    // Reset with an update pending: pending value is dropped, scan restarts.
    repeat (3) step();
    do_load(16'h1234);
    rst_n = 1'b0;
    #1;
    chk("midreset_an", {12'h0, bus.an}, 16'h000F);
    chk("midreset_a", {12'h0, bus.a}, 16'h0000);
    chk("midreset_committed", {15'h0, bus.committed}, 16'h0000);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 1; n <= 5 * DIV; n++) begin
      step();
      chk("restart_an", {12'h0, bus.an}, {12'h0, exp_an(16'h0000, ((n - 1) / DIV) % 4, 1'b0)});
      chk("restart_a", {12'h0, bus.a}, 16'h0000);
      chk("restart_committed", {15'h0, bus.committed}, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
